// File: rtl/mem_arb_pkg.sv
// Shared types for the core-side memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam logic REQ_IFU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/arb2_pick.sv
// Two-way grant selection between IFU and LSU; purely combinational.
module arb2_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic ifu_valid,
   input  logic lsu_valid,
   input  logic last_grant,
   output logic grant_any,
   output logic grant_id
);

   // On contention: LSU under fixed priority, otherwise whoever was not granted last.
   always_comb begin
      grant_any = ifu_valid | lsu_valid;
      grant_id  = REQ_IFU;
      if (ifu_valid && lsu_valid) begin
         if (FIXED_PRIO != 0) grant_id = REQ_LSU;
         else                 grant_id = ~last_grant;
      end else if (lsu_valid) begin
         grant_id = REQ_LSU;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU with a single outstanding
// transaction; the owner keeps the port from grant until its response handshake.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            ifu_req_valid,
   output logic            ifu_req_ready,
   input  logic [AW-1:0]   ifu_req_addr,
   output logic            ifu_rsp_valid,
   input  logic            ifu_rsp_ready,
   output logic [DW-1:0]   ifu_rsp_rdata,

   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [AW-1:0]   lsu_req_addr,
   input  logic            lsu_req_wen,
   input  logic [DW-1:0]   lsu_req_wdata,
   input  logic [DW/8-1:0] lsu_req_wmask,
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [DW-1:0]   lsu_rsp_rdata,

   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [AW-1:0]   mem_req_addr,
   output logic            mem_req_wen,
   output logic [DW-1:0]   mem_req_wdata,
   output logic [DW/8-1:0] mem_req_wmask,
   input  logic            mem_rsp_valid,
   output logic            mem_rsp_ready,
   input  logic [DW-1:0]   mem_rsp_rdata
);

   arb_state_e state, state_nxt;
   logic       owner, owner_nxt;
   logic       last_grant, last_grant_nxt;
   logic       grant_any, grant_id;
   logic       rsp_ready_sel;

   arb2_pick #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .ifu_valid  (ifu_req_valid),
      .lsu_valid  (lsu_req_valid),
      .last_grant (last_grant),
      .grant_any  (grant_any),
      .grant_id   (grant_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= REQ_IFU;
         last_grant <= REQ_IFU;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next state plus owner-steered request/response muxes; everything idles at 0.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      rsp_ready_sel  = 1'b0;

      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_rsp_valid  = 1'b0;
      lsu_rsp_valid  = 1'b0;
      ifu_rsp_rdata  = '0;
      lsu_rsp_rdata  = '0;
      mem_req_valid  = 1'b0;
      mem_req_addr   = '0;
      mem_req_wen    = 1'b0;
      mem_req_wdata  = '0;
      mem_req_wmask  = '0;
      mem_rsp_ready  = 1'b0;

      case (state)
         IDLE: begin
            if (grant_any) begin
               owner_nxt      = grant_id;
               last_grant_nxt = grant_id;
               state_nxt      = REQ;
            end
         end

         REQ: begin
            mem_req_valid = 1'b1;
            if (owner == REQ_LSU) begin
               mem_req_addr  = lsu_req_addr;
               mem_req_wen   = lsu_req_wen;
               mem_req_wdata = lsu_req_wdata;
               mem_req_wmask = lsu_req_wmask;
               lsu_req_ready = mem_req_ready;
            end else begin
               mem_req_addr  = ifu_req_addr;
               ifu_req_ready = mem_req_ready;
            end
            if (mem_req_ready) state_nxt = RESP;
         end

         RESP: begin
            if (owner == REQ_LSU) begin
               rsp_ready_sel = lsu_rsp_ready;
               lsu_rsp_valid = mem_rsp_valid;
               lsu_rsp_rdata = mem_rsp_rdata;
            end else begin
               rsp_ready_sel = ifu_rsp_ready;
               ifu_rsp_valid = mem_rsp_valid;
               ifu_rsp_rdata = mem_rsp_rdata;
            end
            mem_rsp_ready = rsp_ready_sel;
            if (mem_rsp_valid && rsp_ready_sel) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
   logic [AW-1:0] ifu_req_addr;
   logic [DW-1:0] ifu_rsp_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
   logic [AW-1:0] lsu_req_addr;
   logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
   logic [MW-1:0] lsu_req_wmask;
   logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_wdata, mem_rsp_rdata;
   logic [MW-1:0] mem_req_wmask;

   logic          fp_ifu_req_ready, fp_ifu_rsp_valid, fp_lsu_req_ready, fp_lsu_rsp_valid;
   logic [DW-1:0] fp_ifu_rsp_rdata, fp_lsu_rsp_rdata, fp_mem_req_wdata;
   logic          fp_mem_req_valid, fp_mem_req_wen, fp_mem_rsp_ready;
   logic [AW-1:0] fp_mem_req_addr;
   logic [MW-1:0] fp_mem_req_wmask;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
   );

   // Fixed-priority instance shares every input with the round-robin one.
   mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(fp_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(fp_ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(fp_ifu_rsp_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(fp_lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(fp_lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(fp_lsu_rsp_rdata),
      .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(fp_mem_req_addr),
      .mem_req_wen(fp_mem_req_wen), .mem_req_wdata(fp_mem_req_wdata), .mem_req_wmask(fp_mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(fp_mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_in();
      ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b0;
      lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
      lsu_req_wdata = '0;   lsu_req_wmask = '0; lsu_rsp_ready = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      clear_in();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ifu_req_ready"}, ifu_req_ready, 0);
      chk({tag, "_lsu_req_ready"}, lsu_req_ready, 0);
      chk({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, 0);
      chk({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 0);
      chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
      chk({tag, "_mem_rsp_ready"}, mem_rsp_ready, 0);
      chk({tag, "_mem_req_addr"},  mem_req_addr, 0);
      chk({tag, "_mem_req_wen"},   mem_req_wen, 0);
      chk({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
      chk({tag, "_mem_req_wmask"}, mem_req_wmask, 0);
      chk({tag, "_ifu_rsp_rdata"}, ifu_rsp_rdata, 0);
      chk({tag, "_lsu_rsp_rdata"}, lsu_rsp_rdata, 0);
   endtask

   // Randomized-phase model state
   logic [31:0] mem_model [16];
   bit          grant_due, in_req, pend, own, m_last, cur_wen, drop_i, drop_l;
   bit          exp_lsu;
   logic [31:0] exp_rd;
   logic [3:0]  idx;

   initial begin
      rst = 1'b1;
      clear_in();
      tick();
      settle();
      chk_idle("reset");
      tick();
      rst = 1'b0;

      // IFU-only fetch
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
      mem_req_ready = 1'b1; ifu_rsp_ready = 1'b1;
      settle();
      chk("t1_idle_no_ack", ifu_req_ready, 0);
      chk("t1_idle_no_memreq", mem_req_valid, 0);
      tick();
      settle();
      chk("t1_req_valid", mem_req_valid, 1);
      chk("t1_req_addr", mem_req_addr, 32'h8000_0000);
      chk("t1_req_wen", mem_req_wen, 0);
      chk("t1_ifu_ready", ifu_req_ready, 1);
      chk("t1_lsu_ready", lsu_req_ready, 0);
      tick();
      ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0413;
      settle();
      chk("t1_rsp_valid", ifu_rsp_valid, 1);
      chk("t1_rsp_rdata", ifu_rsp_rdata, 32'h0000_0413);
      chk("t1_mem_rsp_ready", mem_rsp_ready, 1);
      chk("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
      tick();
      mem_rsp_valid = 1'b0;
      settle();
      chk_idle("t1_after");
      tick();
      clear_in();

      // LSU store held off by memory for three cycles
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b1;
      lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011;
      settle();
      chk("t2_idle_no_ack", lsu_req_ready, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         mem_req_ready = (i == 3);
         settle();
         chk("t2_req_valid", mem_req_valid, 1);
         chk("t2_req_addr", mem_req_addr, 32'h8000_0100);
         chk("t2_req_wen", mem_req_wen, 1);
         chk("t2_req_wdata", mem_req_wdata, 32'hDEAD_BEEF);
         chk("t2_req_wmask", mem_req_wmask, 4'b0011);
         chk("t2_lsu_ready", lsu_req_ready, (i == 3));
         tick();
      end
      lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678; lsu_rsp_ready = 1'b1;
      settle();
      chk("t2_rsp_valid", lsu_rsp_valid, 1);
      chk("t2_rsp_rdata", lsu_rsp_rdata, 32'h1234_5678);
      chk("t2_ifu_rsp_valid", ifu_rsp_valid, 0);
      tick();
      mem_rsp_valid = 1'b0;
      settle();
      chk("t2_single_rsp", lsu_rsp_valid, 0);
      tick();
      clear_in();

      // Both requesting continuously, from reset
      reset_dut();
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0200;
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0300; lsu_req_wdata = 32'h1111; lsu_req_wmask = 4'hF;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0000;
      ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_lsu = (k % 2 == 0);
         settle();
         chk("t3_idle_ifu_ready", ifu_req_ready, 0);
         chk("t3_fp_idle_ifu_ready", fp_ifu_req_ready, 0);
         tick();
         settle();
         chk("t3_lsu_grant", lsu_req_ready, exp_lsu);
         chk("t3_ifu_grant", ifu_req_ready, !exp_lsu);
         chk("t3_addr", mem_req_addr, exp_lsu ? 32'h8000_0300 : 32'h8000_0200);
         chk("t3_wdata", mem_req_wdata, exp_lsu ? 32'h1111 : 32'h0);
         chk("t3_fp_lsu_grant", fp_lsu_req_ready, 1);
         chk("t3_fp_ifu_ready", fp_ifu_req_ready, 0);
         chk("t3_fp_req_valid", fp_mem_req_valid, 1);
         chk("t3_fp_addr", fp_mem_req_addr, 32'h8000_0300);
         chk("t3_fp_wen", fp_mem_req_wen, 0);
         chk("t3_fp_wdata", fp_mem_req_wdata, 32'h1111);
         chk("t3_fp_wmask", fp_mem_req_wmask, 4'hF);
         tick();
         settle();
         chk("t3_rsp_lsu", lsu_rsp_valid, exp_lsu);
         chk("t3_rsp_ifu", ifu_rsp_valid, !exp_lsu);
         chk("t3_fp_rsp_lsu", fp_lsu_rsp_valid, 1);
         chk("t3_fp_rsp_rdata", fp_lsu_rsp_rdata, 32'h0BAD_0000);
         chk("t3_fp_rsp_ifu", fp_ifu_rsp_valid, 0);
         chk("t3_fp_ifu_rdata", fp_ifu_rsp_rdata, 0);
         chk("t3_fp_mem_rsp_ready", fp_mem_rsp_ready, 1);
         chk("t3_fp_resp_ifu_ready", fp_ifu_req_ready, 0);
         if (k == 3) begin
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
         end
         tick();
      end
      clear_in();

      // Response backpressure from the IFU while the LSU waits
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010; mem_req_ready = 1'b1;
      tick();
      settle();
      chk("t4_ifu_ready", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0400; lsu_req_wen = 1'b1;
      lsu_req_wdata = 32'h55; lsu_req_wmask = 4'hF;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("t4_mem_rsp_ready_low", mem_rsp_ready, 0);
         chk("t4_ifu_rsp_valid", ifu_rsp_valid, 1);
         chk("t4_lsu_held", lsu_req_ready, 0);
         chk("t4_still_resp", mem_req_valid, 0);
         tick();
      end
      ifu_rsp_ready = 1'b1;
      settle();
      chk("t4_mem_rsp_ready", mem_rsp_ready, 1);
      chk("t4_ifu_rdata", ifu_rsp_rdata, 32'hCAFE_F00D);
      chk("t4_lsu_held2", lsu_req_ready, 0);
      tick();
      mem_rsp_valid = 1'b0;
      settle();
      chk("t4_bubble_lsu_ready", lsu_req_ready, 0);
      chk("t4_bubble_ifu_rsp", ifu_rsp_valid, 0);
      tick();
      settle();
      chk("t4_lsu_granted", lsu_req_ready, 1);
      chk("t4_lsu_addr", mem_req_addr, 32'h8000_0400);
      chk("t4_lsu_wen", mem_req_wen, 1);
      tick();
      lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1; lsu_rsp_ready = 1'b1;
      settle();
      chk("t4_lsu_rsp", lsu_rsp_valid, 1);
      tick();
      clear_in();

      // Reset while a response is pending
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020; mem_req_ready = 1'b1;
      tick();
      tick();
      ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h99;
      settle();
      chk("t5_in_resp", ifu_rsp_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; ifu_rsp_ready = 1'b1;
      settle();
      chk_idle("t5_after_rst");
      tick();
      mem_rsp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
      tick();
      settle();
      chk("t5_fresh_ready", ifu_req_ready, 1);
      chk("t5_fresh_addr", mem_req_addr, 32'h8000_0040);
      tick();
      ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h77;
      settle();
      chk("t5_fresh_rsp", ifu_rsp_valid, 1);
      chk("t5_fresh_rdata", ifu_rsp_rdata, 32'h77);
      tick();
      clear_in();

      // Randomized traffic against a transaction-level model
      reset_dut();
      for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
      grant_due = 0; in_req = 0; pend = 0; own = 0; m_last = 0; cur_wen = 0; exp_rd = '0;
      for (int c = 0; c < 800; c++) begin
         if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'($urandom_range(0, 15)) << 2;
         end
         if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
            lsu_req_valid = 1'b1;
            lsu_req_addr  = 32'h100 | (32'($urandom_range(0, 15)) << 2);
            lsu_req_wen   = 1'($urandom_range(0, 1));
            lsu_req_wdata = $urandom;
            lsu_req_wmask = 4'($urandom_range(0, 15));
         end
         mem_req_ready = 1'($urandom_range(0, 1));
         ifu_rsp_ready = 1'($urandom_range(0, 1));
         lsu_rsp_ready = 1'($urandom_range(0, 1));
         mem_rsp_valid = pend && ($urandom_range(0, 3) != 0);
         mem_rsp_rdata = (pend && !cur_wen) ? exp_rd : $urandom;
         settle();

         if (grant_due) begin
            in_req    = 1;
            grant_due = 0;
         end
         chk("rnd_mem_req_valid", mem_req_valid, in_req);
         if (in_req) begin
            chk("rnd_addr", mem_req_addr, own ? lsu_req_addr : ifu_req_addr);
            chk("rnd_wen", mem_req_wen, own ? lsu_req_wen : 1'b0);
            chk("rnd_wdata", mem_req_wdata, own ? lsu_req_wdata : 32'h0);
            chk("rnd_wmask", mem_req_wmask, own ? lsu_req_wmask : 4'h0);
            chk("rnd_ifu_ready", ifu_req_ready, !own && mem_req_ready);
            chk("rnd_lsu_ready", lsu_req_ready, own && mem_req_ready);
         end else begin
            chk("rnd_ifu_ready_off", ifu_req_ready, 0);
            chk("rnd_lsu_ready_off", lsu_req_ready, 0);
         end
         if (pend) begin
            chk("rnd_mem_rsp_ready", mem_rsp_ready, own ? lsu_rsp_ready : ifu_rsp_ready);
            chk("rnd_ifu_rsp_valid", ifu_rsp_valid, !own && mem_rsp_valid);
            chk("rnd_lsu_rsp_valid", lsu_rsp_valid, own && mem_rsp_valid);
            chk("rnd_owner_rdata", own ? lsu_rsp_rdata : ifu_rsp_rdata, mem_rsp_rdata);
            chk("rnd_other_rdata", own ? ifu_rsp_rdata : lsu_rsp_rdata, 0);
         end else begin
            chk("rnd_mem_rsp_ready_off", mem_rsp_ready, 0);
            chk("rnd_ifu_rsp_off", ifu_rsp_valid, 0);
            chk("rnd_lsu_rsp_off", lsu_rsp_valid, 0);
         end
         if (!in_req && !pend) chk("rnd_idle_addr", mem_req_addr, 0);

         drop_i = 0;
         drop_l = 0;
         if (!in_req && !pend) begin
            if (ifu_req_valid || lsu_req_valid) begin
               grant_due = 1;
               own       = (ifu_req_valid && lsu_req_valid) ? !m_last : lsu_req_valid;
               m_last    = own;
            end
         end else if (in_req) begin
            if (mem_req_ready) begin
               in_req  = 0;
               pend    = 1;
               idx     = own ? lsu_req_addr[5:2] : ifu_req_addr[5:2];
               cur_wen = own && lsu_req_wen;
               if (cur_wen) begin
                  for (int b = 0; b < 4; b++)
                     if (lsu_req_wmask[b]) mem_model[idx][8*b +: 8] = lsu_req_wdata[8*b +: 8];
               end else begin
                  exp_rd = mem_model[idx];
               end
               if (own) drop_l = 1;
               else     drop_i = 1;
            end
         end else if (mem_rsp_valid && (own ? lsu_rsp_ready : ifu_rsp_ready)) begin
            if (!cur_wen) chk("rnd_read_data", own ? lsu_rsp_rdata : ifu_rsp_rdata, exp_rd);
            pend = 0;
         end

         tick();
         if (drop_i) ifu_req_valid = 1'b0;
         if (drop_l) lsu_req_valid = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
